// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, absorbs the 1-cycle RAM read latency, queues {pc, inst} for decode.
// Optional build macro FETCH_MISALIGN_EN adds out_misalign and halts fetch on misaligned redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 14
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [31:0]       inst_in,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_inst
`ifdef FETCH_MISALIGN_EN
  ,
  output logic              out_misalign
`endif
);

`ifdef FETCH_MISALIGN_EN
  typedef struct packed {
    logic        mis;
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
`else
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;
`endif

  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]  count_q, count_d;
  entry_t      fifo_q [2];
  entry_t      fifo_d [2];

  logic        pop;
  logic        push;
  logic        slot;
  logic        issue;
  logic        wr_idx;
  logic [2:0]  occupancy;
  entry_t      push_entry;

`ifdef FETCH_MISALIGN_EN
  logic        inflight_mis_q, inflight_mis_d;
  logic        halt_q, halt_d;
  logic        pend_q, pend_d;
  logic        inject;
`else
  logic        unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  assign inst_addr = pc_q[ADDR_W-1:0];
  assign out_valid = (count_q != 2'd0) & ~redirect;
  assign out_pc    = fifo_q[0].pc;
  assign out_inst  = fifo_q[0].inst;
`ifdef FETCH_MISALIGN_EN
  assign out_misalign = fifo_q[0].mis;
`endif

  always_comb begin
    pop       = out_valid & out_ready;
    push      = inflight_q & ~redirect;
    // Words queued plus the one returning must still fit after this cycle's pop.
    occupancy = {2'b00, inflight_q} + {1'b0, count_q};
    slot      = ~redirect & (occupancy <= (3'd1 + {2'b00, pop}));
`ifdef FETCH_MISALIGN_EN
    issue     = slot & ~halt_q;
    inject    = slot & pend_q;
`else
    issue     = slot;
`endif

    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect) begin
`ifdef FETCH_MISALIGN_EN
      pc_d = redirect_pc;
`else
      pc_d = {redirect_pc[31:2], 2'b00};
`endif
    end else if (issue) begin
      pc_d          = pc_q + 32'd4;
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end
`ifdef FETCH_MISALIGN_EN
    else if (inject) begin
      // Synthetic entry rides the normal response path; RAM data is ignored.
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end

    inflight_mis_d = inject;
    halt_d         = halt_q;
    pend_d         = pend_q;
    if (redirect) begin
      halt_d = |redirect_pc[1:0];
      pend_d = |redirect_pc[1:0];
    end else if (inject) begin
      pend_d = 1'b0;
    end
`endif

    push_entry.pc   = inflight_pc_q;
`ifdef FETCH_MISALIGN_EN
    push_entry.inst = inflight_mis_q ? NOP_INST : inst_in;
    push_entry.mis  = inflight_mis_q;
`else
    push_entry.inst = inst_in;
`endif

    fifo_d[0] = fifo_q[0];
    fifo_d[1] = fifo_q[1];
    count_d   = count_q;
    // Tail slot after an optional pop: shift happens first, then the push lands behind it.
    wr_idx    = count_q[1] | (count_q[0] & ~pop);
    if (redirect) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        fifo_d[0] = fifo_q[1];
      end
      if (push) begin
        fifo_d[wr_idx] = push_entry;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= 2'd0;
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
`ifdef FETCH_MISALIGN_EN
      inflight_mis_q <= 1'b0;
      halt_q         <= 1'b0;
      pend_q         <= 1'b0;
`endif
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      fifo_q[0]     <= fifo_d[0];
      fifo_q[1]     <= fifo_d[1];
`ifdef FETCH_MISALIGN_EN
      inflight_mis_q <= inflight_mis_d;
      halt_q         <= halt_d;
      pend_q         <= pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random redirect/stall traffic checked against
// a program-order stream model (next expected pc, RAM word derived from the address).
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          ADDR_W   = 14;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] inst_addr;
  logic [31:0]       inst_in;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [31:0]       out_inst;
`ifdef FETCH_MISALIGN_EN
  logic              out_misalign;
`endif

  fetch_unit #(.RESET_PC(RESET_PC), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_addr   (inst_addr),
    .inst_in     (inst_in),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst)
`ifdef FETCH_MISALIGN_EN
    ,
    .out_misalign(out_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16KB synchronous RAM, word i holds A000_0000 + i.
  always @(posedge clk) inst_in <= 32'hA000_0000 + {20'd0, inst_addr[13:2]};

  int checks = 0;
  int passed = 0;

  // Stream model state.
  logic [31:0] exp_pc;
  int          since;
  bit          first_pending;
  bit          all_ready;
  int          stall_run;
  bit          prev_hold;
  logic [31:0] prev_pc;
  logic [31:0] prev_inst;
  bit          mis_mode;
  bit          mis_done;
  logic [31:0] mis_pc;

  function automatic logic [31:0] ram_word(input logic [31:0] pc);
    return 32'hA000_0000 + ((pc % 32'd16384) / 32'd4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic flush_model(input logic [31:0] tgt);
    since         = 0;
    first_pending = 1;
    all_ready     = 1;
    stall_run     = 0;
    prev_hold     = 0;
    mis_mode      = 0;
    mis_done      = 0;
    mis_pc        = tgt;
`ifdef FETCH_MISALIGN_EN
    exp_pc = tgt;
    if (tgt[1:0] != 2'b00) begin
      mis_mode      = 1;
      first_pending = 0;
      all_ready     = 0;
    end
`else
    exp_pc = tgt & 32'hFFFF_FFFC;
`endif
  endtask

  task automatic observe(input logic rd, input logic [31:0] rpc, input logic rdy);
    since++;
    if (rd) begin
      chk("redirect_valid_low", {31'd0, out_valid}, 32'd0);
    end else begin
      if (first_pending && since < 3) chk("fill_valid_low", {31'd0, out_valid}, 32'd0);
      if (first_pending && since == 3) begin
        chk("first_latency", {31'd0, out_valid}, 32'd1);
        first_pending = 0;
      end
      if (all_ready && since > 3) chk("throughput", {31'd0, out_valid}, 32'd1);
      if (prev_hold) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_pc", out_pc, prev_pc);
        chk("stall_inst", out_inst, prev_inst);
      end
      if (!mis_mode && stall_run >= 3 && since >= 4)
        chk("stall_issue_stop", {18'd0, inst_addr}, (exp_pc + 32'd8) & 32'h3FFF);
      if (mis_mode) begin
        if (mis_done) begin
          chk("halt_no_valid", {31'd0, out_valid}, 32'd0);
        end else if (out_valid && rdy) begin
          chk("mis_pc", out_pc, mis_pc);
          chk("mis_inst", out_inst, 32'h0000_0013);
`ifdef FETCH_MISALIGN_EN
          chk("mis_flag", {31'd0, out_misalign}, 32'd1);
`endif
          mis_done = 1;
        end
      end else if (out_valid && rdy) begin
        chk("hs_pc", out_pc, exp_pc);
        chk("hs_inst", out_inst, ram_word(exp_pc));
`ifdef FETCH_MISALIGN_EN
        chk("hs_misalign", {31'd0, out_misalign}, 32'd0);
`endif
        exp_pc = exp_pc + 32'd4;
      end
    end
    prev_hold = !rd && out_valid && !rdy;
    prev_pc   = out_pc;
    prev_inst = out_inst;
    stall_run = (!rd && !rdy) ? stall_run + 1 : 0;
    if (!rdy) all_ready = 0;
    if (rd) flush_model(rpc);
  endtask

  task automatic cyc(input logic rd, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    redirect    = rd;
    redirect_pc = rpc;
    out_ready   = rdy;
    #1;
    observe(rd, rpc, rdy);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3;
    rst       = 1'b1;
    redirect  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_addr", {18'd0, inst_addr}, RESET_PC & 32'h3FFF);
`ifdef FETCH_MISALIGN_EN
    chk("rst_misalign", {31'd0, out_misalign}, 32'd0);
`endif
    @(posedge clk);
    #2;
    rst = 1'b0;
    flush_model(RESET_PC);
  endtask

  initial begin
    logic        rd;
    logic [31:0] rpc;
    logic        rdy;
    int          bias;

    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    out_ready   = 1'b1;

    // Fill and stream from reset.
    pulse_reset();
    repeat (8) cyc(1'b0, 32'd0, 1'b1);

    // Decode stall right at first valid, then release.
    pulse_reset();
    repeat (2) cyc(1'b0, 32'd0, 1'b1);
    repeat (5) cyc(1'b0, 32'd0, 1'b0);
    repeat (6) cyc(1'b0, 32'd0, 1'b1);

    // Redirect while pc 8 is returning and pc 4 is at the head.
    pulse_reset();
    repeat (3) cyc(1'b0, 32'd0, 1'b1);
    cyc(1'b1, 32'h0000_0100, 1'b1);
    repeat (6) cyc(1'b0, 32'd0, 1'b1);

    // PC wrap across 2^32 with RAM aliasing.
    cyc(1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (6) cyc(1'b0, 32'd0, 1'b1);

    // Back-to-back redirects: last wins.
    cyc(1'b1, 32'h0000_0300, 1'b1);
    cyc(1'b1, 32'h0000_0400, 1'b1);
    repeat (6) cyc(1'b0, 32'd0, 1'b1);

    // Misaligned target: halt entry with the feature, low bits dropped without it.
    cyc(1'b1, 32'h0000_0102, 1'b1);
    repeat (8) cyc(1'b0, 32'd0, 1'b1);
`ifdef FETCH_MISALIGN_EN
    chk("mis_entry_seen", {31'd0, mis_done}, 32'd1);
`endif
    cyc(1'b1, 32'h0000_0200, 1'b1);
    repeat (6) cyc(1'b0, 32'd0, 1'b1);

    // Random redirect/stall traffic, with alternating ready bias.
    for (int i = 0; i < 1500; i++) begin
      bias = ((i % 300) < 150) ? 85 : 30;
      rd   = ($urandom_range(0, 29) == 0);
      rpc  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      rdy  = ($urandom_range(0, 99) < bias);
      cyc(rd, rpc, rdy);
    end

    // Mid-stream asynchronous reset, then a clean restart.
    pulse_reset();
    repeat (6) cyc(1'b0, 32'd0, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
